icache_refill_responder: RTL and testbench
==========================================

# icache_refill_responder

Sequential, direct-mapped instruction cache that answers the IFQ's line-fetch protocol: `PC_in`, `rd_en`, `abort` in; `D_out`, `d_out_valid` out. Hits return a 128-bit line one cycle after the request. Misses run a single-outstanding refill handshake to a backing instruction memory, install the line, and then respond. It sits between the IFQ and instruction memory, in place of the combinational instruction ROM.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction width.
- `CACHE_LINE_WIDTH`, 128: line width, 4 instructions.
- `CACHE_DEPTH`, 64: number of lines. Must be a power of two. `IDX_W = $clog2(CACHE_DEPTH)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `PC_in`  in  32  request address. Bits [3:0] are ignored.
- `rd_en`  in  1  request strobe.
- `abort`  in  1  cancels the pending or in-flight request.
- `D_out`  out  128  returned line. Word 0 is in [31:0].
- `d_out_valid`  out  1  one-cycle response pulse.
- `icache_ready`  out  1  high when a request can be accepted (state IDLE).
- `mem_req`  out  1  refill request to backing memory.
- `mem_addr`  out  32  refill line address, `{PC[31:4],4'b0}`.
- `mem_ack`  in  1  refill data valid. Meaningful only while `mem_req` is high.
- `mem_data`  in  128  refill line.
- `hit_count`  out  32  hit counter (see Configuration).
- `miss_count`  out  32  miss counter (see Configuration).

## Operation
Address split:
- index = `PC_in[4+IDX_W-1:4]`
- tag = `PC_in[31:4+IDX_W]`
- Storage per line: valid bit, tag, data.

Request acceptance:
- A request is accepted when `icache_ready & rd_en & ~abort`.
- `rd_en` is ignored outside IDLE.
- `rd_en` held high in IDLE issues one request per cycle.

FSM:
- **IDLE**
  - Accepted hit: set `resp_q`, load `D_out` from the data array, stay IDLE.
  - Accepted miss: latch line address and tag into `mem_addr`, go to REFILL.
  - No request: `resp_q` = 0.
- **REFILL**
  - `mem_req` = 1. `mem_addr` is held stable.
  - `abort` sets sticky `killed_q`.
  - On `mem_ack`:
    - Write data, tag and valid = 1 into the indexed line.
    - `D_out` <= `mem_data`.
    - `resp_q` <= `~killed_q & ~abort`.
    - Clear `killed_q` and go to IDLE.
  - `mem_req` is deasserted in the cycle after the ack.

Output gating and other rules:
- `d_out_valid = resp_q & ~abort`: an abort in the response cycle suppresses the pulse.
- `D_out` holds its last value when `d_out_valid` is low.
- An aborted refill still installs the line. No response is produced for it.
- `mem_ack` while in IDLE is ignored.
- The cache never self-invalidates. All valid bits clear only on reset.

Reset (`rst` = 0), asynchronous:
- State = IDLE.
- All valid bits = 0.
- `resp_q`, `d_out_valid`, `mem_req`, `killed_q` = 0.
- `D_out` = 0, `mem_addr` = 0.
- Counters = 0.
- `icache_ready` = 1 once reset is released.
- Reset mid-refill drops `mem_req` immediately. A later `mem_ack` has no effect.

## Timing
- Hit: request accepted in cycle N → `d_out_valid` in N+1. Back-to-back hits are accepted every cycle.
- Miss: request in cycle N → `mem_req` high from N+1 until `mem_ack` at cycle M → `d_out_valid` and `icache_ready` in M+1.
  - Minimum miss latency, with `mem_ack` in N+1: 2 cycles.
- A new request accepted in cycle M+1 to the just-refilled line hits, with response in M+2.
- Request and `abort` in the same cycle: not accepted, no state change.
- Data-array read on a hit happens in the request cycle. The array may be synchronous-read.

## Configuration
- `ICACHE_PERF_CNT_EN` defined:
  - `hit_count` increments on every accepted hit.
  - `miss_count` increments on every accepted miss, including aborted ones.
  - Both wrap at 2^32.
- `ICACHE_PERF_CNT_EN` undefined: both counter outputs are tied to 0 and no counter flops are built.
- Functional behaviour is otherwise identical.

## Test plan
- Cold miss:
  - Stimulus: reset; `PC_in`=0x0000_0010, `rd_en` 1 cycle; bench acks 3 cycles later with `mem_data`=0x0000_0013_0000_0012_0000_0011_0000_0010.
  - Required: `mem_addr`=0x10; `d_out_valid` 1 cycle after ack with that data; `miss_count`=1.
- Hit after refill:
  - Stimulus: repeat request to 0x14.
  - Required: no `mem_req`; `d_out_valid` next cycle with the same line; `hit_count`=1.
- Conflict miss:
  - Stimulus: 0x0000_0410 after 0x10 (same index 1, different tag).
  - Required: refill with `mem_addr`=0x410, then 0x10 misses again.
- Abort during refill:
  - Stimulus: miss on 0x20, `abort` pulsed before `mem_ack`.
  - Required: no `d_out_valid`; a subsequent request to 0x20 hits in 1 cycle.
- Response-cycle abort and same-cycle abort:
  - Stimulus: `abort` in the hit response cycle; `abort` together with `rd_en`.
  - Required: `d_out_valid` stays 0 in both cases; no refill is started.
- Reset mid-refill:
  - Stimulus: `rst` low while `mem_req`=1.
  - Required: `mem_req` drops asynchronously; all lines invalid, so a request to 0x10 misses.

Source files
------------

// File: rtl/icache_refill_responder.sv
// Direct-mapped instruction cache serving IFQ line fetches, with single-outstanding refill.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_refill_responder #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128,
  parameter int unsigned CACHE_DEPTH      = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 PC_in,
  input  logic                        rd_en,
  input  logic                        abort,
  output logic [CACHE_LINE_WIDTH-1:0] D_out,
  output logic                        d_out_valid,
  output logic                        icache_ready,
  output logic                        mem_req,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ack,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_data,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  localparam int unsigned ADDR_W = 32;
  // Byte offset within a line: byte-in-word bits plus two bits for four words per line.
  localparam int unsigned OFF_W  = $clog2(DATA_WIDTH / 8) + 2;
  localparam int unsigned IDX_W  = $clog2(CACHE_DEPTH);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic                        resp_q, resp_d;
  logic                        killed_q, killed_d;
  logic [CACHE_LINE_WIDTH-1:0] d_out_d;
  logic [ADDR_W-1:0]           mem_addr_d;
  logic                        fill_we;
  logic                        hit_evt;
  logic                        miss_evt;

  logic [CACHE_DEPTH-1:0]      valid_q;
  logic [TAG_W-1:0]            tag_arr  [CACHE_DEPTH];
  logic [CACHE_LINE_WIDTH-1:0] data_arr [CACHE_DEPTH];

  logic [IDX_W-1:0]            req_idx;
  logic [TAG_W-1:0]            req_tag;
  logic [IDX_W-1:0]            fill_idx;
  logic [TAG_W-1:0]            fill_tag;
  logic                        req_hit;
  logic                        accept;

  // Byte offset bits of the request never select anything: a whole line is returned.
  logic                        unused_pc_off;
  assign unused_pc_off = ^PC_in[OFF_W-1:0];

  assign req_idx  = PC_in[OFF_W +: IDX_W];
  assign req_tag  = PC_in[OFF_W+IDX_W +: TAG_W];
  assign fill_idx = mem_addr[OFF_W +: IDX_W];
  assign fill_tag = mem_addr[OFF_W+IDX_W +: TAG_W];

  assign req_hit  = valid_q[req_idx] & (tag_arr[req_idx] == req_tag);
  assign accept   = (state_q == ST_IDLE) & rd_en & ~abort;

  assign icache_ready = (state_q == ST_IDLE);
  assign mem_req      = (state_q == ST_REFILL);
  // An abort arriving in the response cycle still squashes the pulse.
  assign d_out_valid  = resp_q & ~abort;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, response and refill control
  always_comb begin
    state_d    = state_q;
    resp_d     = 1'b0;
    killed_d   = killed_q;
    d_out_d    = D_out;
    mem_addr_d = mem_addr;
    fill_we    = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_hit) begin
            resp_d  = 1'b1;
            d_out_d = data_arr[req_idx];
            hit_evt = 1'b1;
          end else begin
            mem_addr_d = {PC_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            miss_evt   = 1'b1;
            state_d    = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        killed_d = killed_q | abort;
        if (mem_ack) begin
          // The line is installed even when the request was killed.
          fill_we  = 1'b1;
          d_out_d  = mem_data;
          resp_d   = ~killed_q & ~abort;
          killed_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response, address and valid-bit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q   <= 1'b0;
      killed_q <= 1'b0;
      D_out    <= '0;
      mem_addr <= '0;
      valid_q  <= '0;
    end else begin
      resp_q   <= resp_d;
      killed_q <= killed_d;
      D_out    <= d_out_d;
      mem_addr <= mem_addr_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage; contents are qualified by valid_q so need no reset
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_data;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_evt) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_perf_evt;
  assign unused_perf_evt = hit_evt ^ miss_evt;

  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_refill_responder.sv
// Self-checking bench for icache_refill_responder: per-scenario tasks plus a response scoreboard.
module tb_icache_refill_responder;

  localparam logic [127:0] L0   = 128'h0000_0013_0000_0012_0000_0011_0000_0010;
  localparam logic [127:0] L1   = 128'h0000_0413_0000_0412_0000_0411_0000_0410;
  localparam logic [127:0] L2   = 128'h0000_0023_0000_0022_0000_0021_0000_0020;
  localparam logic [127:0] JUNK = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [31:0]  PC_in;
  logic         rd_en;
  logic         abort;
  logic [127:0] D_out;
  logic         d_out_valid;
  logic         icache_ready;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  int unsigned  exp_hits = 0;
  int unsigned  exp_misses = 0;
  logic [127:0] sb [$];

  icache_refill_responder dut (
    .clk          (clk),
    .rst          (rst),
    .PC_in        (PC_in),
    .rd_en        (rd_en),
    .abort        (abort),
    .D_out        (D_out),
    .d_out_valid  (d_out_valid),
    .icache_ready (icache_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_exp(input int unsigned n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Every response pulse must match the oldest expected line.
  always @(negedge clk) begin
    if (rst === 1'b1 && d_out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: D_out=%h with no response expected", D_out);
      end else begin
        logic [127:0] exp_line;
        exp_line = sb.pop_front();
        if (D_out !== exp_line) begin
          bad++;
          $display("FAIL resp_data: got %h want %h", D_out, exp_line);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; PC_in = '0; rd_en = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", d_out_valid); end
    total++; if (D_out !== 128'd0) begin bad++; $display("FAIL rst_d_out: got %h want 0", D_out); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL rst_hit_cnt: got %0d want 0", hit_count); end
    total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL rst_miss_cnt: got %0d want 0", miss_count); end
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", icache_ready); end
  endtask

  task automatic test_cold_miss();
    next_cycle(); PC_in = 32'h10; rd_en = 1'b1;
    @(negedge clk);
    total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL cold_ready: got %b want 1", icache_ready); end
    next_cycle(); rd_en = 1'b0; exp_misses++;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL cold_mem_req: got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL cold_mem_addr: got %h want 00000010", mem_addr); end
    total++; if (icache_ready !== 1'b0) begin bad++; $display("FAIL cold_busy: got %b want 0", icache_ready); end
    next_cycle();
    next_cycle(); mem_ack = 1'b1; mem_data = L0; sb.push_back(L0);
    next_cycle(); mem_ack = 1'b0; mem_data = JUNK;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL cold_valid: got %b want 1", d_out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL cold_req_drop: got %b want 0", mem_req); end
    total++; if (miss_count !== cnt_exp(exp_misses)) begin bad++; $display("FAIL cold_miss_cnt: got %0d want %0d", miss_count, cnt_exp(exp_misses)); end
  endtask

  task automatic test_hit_after_refill();
    next_cycle(); PC_in = 32'h14; rd_en = 1'b1; sb.push_back(L0); exp_hits++;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL hit_req_cycle: got %b want 0", d_out_valid); end
    next_cycle(); rd_en = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL hit_valid: got %b want 1", d_out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hit_no_refill: got %b want 0", mem_req); end
    total++; if (hit_count !== cnt_exp(exp_hits)) begin bad++; $display("FAIL hit_cnt: got %0d want %0d", hit_count, cnt_exp(exp_hits)); end
  endtask

  task automatic test_back_to_back();
    next_cycle(); PC_in = 32'h10; rd_en = 1'b1; sb.push_back(L0); exp_hits++;
    next_cycle(); PC_in = 32'h1C; sb.push_back(L0); exp_hits++;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b want 1", d_out_valid); end
    total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", icache_ready); end
    next_cycle(); rd_en = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second: got %b want 1", d_out_valid); end
    next_cycle();
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", d_out_valid); end
  endtask

  task automatic test_conflict_miss();
    next_cycle(); PC_in = 32'h410; rd_en = 1'b1; exp_misses++;
    next_cycle(); rd_en = 1'b0; mem_ack = 1'b1; mem_data = L1; sb.push_back(L1);
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL conflict_req: got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h410) begin bad++; $display("FAIL conflict_addr: got %h want 00000410", mem_addr); end
    next_cycle(); mem_ack = 1'b0; PC_in = 32'h10; rd_en = 1'b1;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL conflict_min_latency: got %b want 1", d_out_valid); end
    total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL conflict_ready: got %b want 1", icache_ready); end
    next_cycle(); rd_en = 1'b0; exp_misses++;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL conflict_remiss: got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL conflict_remiss_addr: got %h want 00000010", mem_addr); end
    next_cycle(); mem_ack = 1'b1; mem_data = L0; sb.push_back(L0);
    next_cycle(); mem_ack = 1'b0; PC_in = 32'h10; rd_en = 1'b1; sb.push_back(L0); exp_hits++;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL conflict_refill_resp: got %b want 1", d_out_valid); end
    next_cycle(); rd_en = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL refilled_line_hit: got %b want 1", d_out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL refilled_line_no_req: got %b want 0", mem_req); end
  endtask

  task automatic test_abort_refill();
    next_cycle(); PC_in = 32'h20; rd_en = 1'b1; exp_misses++;
    next_cycle(); rd_en = 1'b0; abort = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL abort_req: got %b want 1", mem_req); end
    next_cycle(); abort = 1'b0;
    next_cycle(); mem_ack = 1'b1; mem_data = L2;
    next_cycle(); mem_ack = 1'b0; mem_data = JUNK;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_resp: got %b want 0", d_out_valid); end
    total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", icache_ready); end
    next_cycle(); PC_in = 32'h20; rd_en = 1'b1; sb.push_back(L2); exp_hits++;
    next_cycle(); rd_en = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL abort_line_installed: got %b want 1", d_out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL abort_line_no_req: got %b want 0", mem_req); end
    total++; if (miss_count !== cnt_exp(exp_misses)) begin bad++; $display("FAIL abort_miss_cnt: got %0d want %0d", miss_count, cnt_exp(exp_misses)); end
  endtask

  task automatic test_abort_gating();
    next_cycle(); PC_in = 32'h20; rd_en = 1'b1; exp_hits++;
    next_cycle(); rd_en = 1'b0; abort = 1'b1;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL resp_cycle_abort: got %b want 0", d_out_valid); end
    next_cycle(); abort = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL resp_abort_after: got %b want 0", d_out_valid); end
    next_cycle(); PC_in = 32'h30; rd_en = 1'b1; abort = 1'b1;
    next_cycle(); rd_en = 1'b0; abort = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL same_cycle_no_refill: got %b want 0", mem_req); end
    total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL same_cycle_ready: got %b want 1", icache_ready); end
    next_cycle(); PC_in = 32'h20; rd_en = 1'b1; abort = 1'b1;
    next_cycle(); rd_en = 1'b0; abort = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_hit: got %b want 0", d_out_valid); end
    total++; if (hit_count !== cnt_exp(exp_hits)) begin bad++; $display("FAIL gating_hit_cnt: got %0d want %0d", hit_count, cnt_exp(exp_hits)); end
    total++; if (miss_count !== cnt_exp(exp_misses)) begin bad++; $display("FAIL gating_miss_cnt: got %0d want %0d", miss_count, cnt_exp(exp_misses)); end
  endtask

  task automatic test_idle_ack();
    next_cycle(); mem_ack = 1'b1; mem_data = JUNK;
    next_cycle(); mem_ack = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL idle_ack_resp: got %b want 0", d_out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_ack_req: got %b want 0", mem_req); end
  endtask

  task automatic test_reset_mid_refill();
    next_cycle(); PC_in = 32'h30; rd_en = 1'b1; exp_misses++;
    next_cycle(); rd_en = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL pre_reset_req: got %b want 1", mem_req); end
    #1 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL async_req_drop: got %b want 0", mem_req); end
    total++; if (D_out !== 128'd0) begin bad++; $display("FAIL mid_rst_d_out: got %h want 0", D_out); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL mid_rst_addr: got %h want 0", mem_addr); end
    total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL mid_rst_miss_cnt: got %0d want 0", miss_count); end
    exp_hits = 0; exp_misses = 0;
    next_cycle(); rst = 1'b1;
    next_cycle(); mem_ack = 1'b1; mem_data = JUNK;
    next_cycle(); mem_ack = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL late_ack_ignored: got %b want 0", d_out_valid); end
    next_cycle(); PC_in = 32'h10; rd_en = 1'b1; exp_misses++;
    next_cycle(); rd_en = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL post_reset_miss: got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL post_reset_addr: got %h want 00000010", mem_addr); end
    next_cycle(); mem_ack = 1'b1; mem_data = L0; sb.push_back(L0);
    next_cycle(); mem_ack = 1'b0;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_resp: got %b want 1", d_out_valid); end
    total++; if (miss_count !== cnt_exp(exp_misses)) begin bad++; $display("FAIL post_reset_miss_cnt: got %0d want %0d", miss_count, cnt_exp(exp_misses)); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_refill();
    test_back_to_back();
    test_conflict_miss();
    test_abort_refill();
    test_abort_gating();
    test_idle_ack();
    test_reset_mid_refill();
    next_cycle();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained: %0d responses outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
